// File: rtl/twos_comp_pkg.sv
// Shared types and default sizing for the two's-complement SIMD pipeline.
package twos_comp_pkg;

  typedef enum logic [1:0] {
    MODE_NEG     = 2'b00,
    MODE_ABS     = 2'b01,
    MODE_ABSDIFF = 2'b10,
    MODE_SAD     = 2'b11
  } mode_e;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_LANES     = 4;
  localparam int DEF_ACC_WIDTH = 16;

  // Difference modes treat operands as unsigned and ignore the sign-extension path.
  function automatic logic is_diff_mode(input mode_e m);
    return (m == MODE_ABSDIFF) || (m == MODE_SAD);
  endfunction

endpackage

// File: rtl/twos_comp_lane.sv
// One lane: stage 1 registers the (WIDTH+1)-bit operand/difference and its negation,
// stage 2 registers the selected result and overflow. TWOS_COMP_SAT_EN saturates -2^(WIDTH-1).
module twos_comp_lane
  import twos_comp_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s1_load,
  input  logic             s2_load,
  input  mode_e            in_mode,
  input  mode_e            s1_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y_next,
  output logic [WIDTH-1:0] y,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH:0]   d_in;
  logic [WIDTH-1:0] nd_in;
  logic [WIDTH:0]   s1_d;
  logic [WIDTH-1:0] s1_nd;
  logic             s1_min;

  // Low bits of a negation depend only on low bits, so the negated copy stays WIDTH wide.
  always_comb begin
    d_in  = is_diff_mode(in_mode) ? ({1'b0, a} - {1'b0, b}) : {a[WIDTH-1], a};
    nd_in = ~d_in[WIDTH-1:0] + ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_d   <= '0;
      s1_nd  <= '0;
      s1_min <= 1'b0;
    end else if (s1_load) begin
      s1_d   <= d_in;
      s1_nd  <= nd_in;
      s1_min <= !is_diff_mode(in_mode) && (a == MIN_NEG);
    end
  end

  always_comb begin
    y_next = ((s1_mode == MODE_NEG) || s1_d[WIDTH]) ? s1_nd : s1_d[WIDTH-1:0];
`ifdef TWOS_COMP_SAT_EN
    if (s1_min) y_next = MAX_POS;
`else
    if (s1_min) y_next = MIN_NEG;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y   <= '0;
      ovf <= 1'b0;
    end else if (s2_load) begin
      y   <= y_next;
      ovf <= s1_min;
    end
  end

endmodule

// File: rtl/twos_comp_pipe.sv
// Multi-lane NEG/ABS/ABSDIFF/SAD pipeline with valid/ready handshake and saturating SAD
// accumulator. Optional macro TWOS_COMP_SAT_EN saturates NEG/ABS of the most negative value.
module twos_comp_pipe
  import twos_comp_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int LANES     = DEF_LANES,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             mode,
  input  logic [LANES*WIDTH-1:0] a,
  input  logic [LANES*WIDTH-1:0] b,
  input  logic                   acc_clr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] y,
  output logic [LANES-1:0]       ovf,
  output logic [ACC_WIDTH-1:0]   sad,
  output logic                   acc_ovf
);

  logic                   en;
  logic                   s1_load;
  logic                   s2_load;
  logic                   s1_valid;
  mode_e                  s1_mode;
  mode_e                  out_mode;
  logic [LANES*WIDTH-1:0] y_next;
  logic [ACC_WIDTH-1:0]   lane_sum;
  logic [ACC_WIDTH-1:0]   sum_r;
  logic [ACC_WIDTH-1:0]   acc_base;
  logic [ACC_WIDTH:0]     acc_total;
  logic                   sad_done;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign s1_load  = en && in_valid;
  assign s2_load  = en && s1_valid;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    twos_comp_lane #(.WIDTH(WIDTH)) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .s1_load (s1_load),
      .s2_load (s2_load),
      .in_mode (mode_e'(mode)),
      .s1_mode (s1_mode),
      .a       (a[i*WIDTH +: WIDTH]),
      .b       (b[i*WIDTH +: WIDTH]),
      .y_next  (y_next[i*WIDTH +: WIDTH]),
      .y       (y[i*WIDTH +: WIDTH]),
      .ovf     (ovf[i])
    );
  end

  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_sum = lane_sum + ACC_WIDTH'(y_next[i*WIDTH +: WIDTH]);
    end
  end

  // Valids always advance with en so bubbles travel as empty slots; payload loads only with data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_mode   <= MODE_NEG;
      out_valid <= 1'b0;
      out_mode  <= MODE_NEG;
      sum_r     <= '0;
    end else if (en) begin
      s1_valid  <= in_valid;
      out_valid <= s1_valid;
      if (in_valid) s1_mode <= mode_e'(mode);
      if (s1_valid) begin
        out_mode <= s1_mode;
        sum_r    <= lane_sum;
      end
    end
  end

  assign sad_done  = out_valid && out_ready && (out_mode == MODE_SAD);
  assign acc_base  = acc_clr ? '0 : sad;
  assign acc_total = {1'b0, acc_base} + {1'b0, sum_r};

  // A clear coinciding with a completing SAD beat restarts the total from that beat's sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sad     <= '0;
      acc_ovf <= 1'b0;
    end else if (sad_done) begin
      if (acc_total[ACC_WIDTH]) begin
        sad     <= '1;
        acc_ovf <= 1'b1;
      end else begin
        sad     <= acc_total[ACC_WIDTH-1:0];
        acc_ovf <= acc_clr ? 1'b0 : acc_ovf;
      end
    end else if (acc_clr) begin
      sad     <= '0;
      acc_ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_twos_comp_pipe.sv
// Scoreboard bench for twos_comp_pipe: stimulus pushes model results, a monitor pops and compares.
module tb_twos_comp_pipe;

  localparam int W  = 8;
  localparam int L  = 4;
  localparam int AW = 16;

  logic           clk       = 1'b0;
  logic           rst_n     = 1'b0;
  logic           in_valid  = 1'b0;
  logic           in_ready;
  logic [1:0]     mode      = 2'b00;
  logic [L*W-1:0] a         = '0;
  logic [L*W-1:0] b         = '0;
  logic           acc_clr   = 1'b0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [L*W-1:0] y;
  logic [L-1:0]   ovf;
  logic [AW-1:0]  sad;
  logic           acc_ovf;

  typedef struct {
    logic [L*W-1:0] y;
    logic [L-1:0]   ovf;
    logic [1:0]     mode;
  } exp_t;

  exp_t sb[$];
  int   checks     = 0;
  int   errors     = 0;
  int   sad_m      = 0;
  bit   acc_ovf_m  = 1'b0;
  int   ready_mode = 0;

  twos_comp_pipe #(.WIDTH(W), .LANES(L), .ACC_WIDTH(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .a         (a),
    .b         (b),
    .acc_clr   (acc_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .ovf       (ovf),
    .sad       (sad),
    .acc_ovf   (acc_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference: lane results from arithmetic on signed/unsigned integer interpretations.
  function automatic exp_t model(input logic [1:0] m, input logic [L*W-1:0] av, input logic [L*W-1:0] bv);
    exp_t e;
    e.y    = '0;
    e.ovf  = '0;
    e.mode = m;
    for (int i = 0; i < L; i++) begin
      int ai = int'(av[i*W +: W]);
      int bi = int'(bv[i*W +: W]);
      int sa = (ai >= 128) ? ai - 256 : ai;
      int r;
      bit o  = 1'b0;
      case (m)
        2'b00:   begin r = -sa; o = (sa == -128); end
        2'b01:   begin r = (sa < 0) ? -sa : sa; o = (sa == -128); end
        default: r = (ai > bi) ? ai - bi : bi - ai;
      endcase
`ifdef TWOS_COMP_SAT_EN
      if (o) r = 127;
`endif
      e.y[i*W +: W] = W'(r);
      e.ovf[i]      = o;
    end
    return e;
  endfunction

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'b0;
      default: out_ready = ($urandom_range(0, 2) != 0);
    endcase
  end

  // Monitor: compares the head of the scoreboard whenever a beat is presented, tracks sad.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      sad_m     = 0;
      acc_ovf_m = 1'b0;
    end else begin
      bit   done_sad;
      int   sum;
      int   base;
      exp_t e;
      done_sad = 1'b0;
      sum      = 0;
      checkOutput("sad", 64'(sad), 64'(sad_m));
      checkOutput("acc_ovf", 64'(acc_ovf), 64'(acc_ovf_m));
      if (out_valid && !out_ready) checkOutput("in_ready_stall", 64'(in_ready), 64'd0);
      if (!out_valid) checkOutput("in_ready_idle", 64'(in_ready), 64'd1);
      if (out_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_beat: got out_valid=1 required no beat pending at %0t", $time);
        end else begin
          checkOutput("y", 64'(y), 64'(sb[0].y));
          checkOutput("ovf", 64'(ovf), 64'(sb[0].ovf));
          if (out_ready) begin
            e = sb.pop_front();
            if (e.mode == 2'b11) begin
              done_sad = 1'b1;
              for (int i = 0; i < L; i++) sum += int'(e.y[i*W +: W]);
            end
          end
        end
      end
      base = acc_clr ? 0 : sad_m;
      if (acc_clr) acc_ovf_m = 1'b0;
      if (done_sad) begin
        if (base + sum > 65535) begin
          sad_m     = 65535;
          acc_ovf_m = 1'b1;
        end else begin
          sad_m = base + sum;
        end
      end else begin
        sad_m = base;
      end
    end
  end

  task automatic applyStimulus(input logic [1:0] m, input logic [L*W-1:0] av, input logic [L*W-1:0] bv);
    bit ok = 1'b0;
    mode     = m;
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(model(m, av, bv));
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (!ok) checkOutput("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    if (!ok) checkOutput("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  task automatic pulseClear();
    acc_clr = 1'b1;
    @(posedge clk);
    #1;
    acc_clr = 1'b0;
  endtask

  initial begin
    logic [L*W-1:0] ra;
    logic [L*W-1:0] rb;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_y", 64'(y), 64'd0);
    checkOutput("rst_ovf", 64'(ovf), 64'd0);
    checkOutput("rst_sad", 64'(sad), 64'd0);
    checkOutput("rst_acc_ovf", 64'(acc_ovf), 64'd0);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // NEG with exact two-cycle latency
    applyStimulus(2'b00, {8'h7F, 8'h00, 8'hFF, 8'h05}, '0);
    @(negedge clk);
    checkOutput("neg_lat1", 64'(out_valid), 64'd0);
    @(negedge clk);
    checkOutput("neg_lat2", 64'(out_valid), 64'd1);
    checkOutput("neg_y", 64'(y), 64'h81_00_01_FB);
    checkOutput("neg_ovf", 64'(ovf), 64'd0);
    drain();

    // ABS of the most negative value
    applyStimulus(2'b01, {8'h85, 8'h7F, 8'h03, 8'h80}, '0);
    @(negedge clk);
    @(negedge clk);
`ifdef TWOS_COMP_SAT_EN
    checkOutput("abs_min_y", 64'(y), 64'h7B_7F_03_7F);
`else
    checkOutput("abs_min_y", 64'(y), 64'h7B_7F_03_80);
`endif
    checkOutput("abs_min_ovf", 64'(ovf), 64'h1);
    drain();

    // SAD accumulation and clear
    pulseClear();
    for (int k = 1; k <= 3; k++) begin
      applyStimulus(2'b11, {8'd255, 8'd0, 8'd200, 8'd10}, {8'd0, 8'd0, 8'd100, 8'd20});
      drain();
      checkOutput("sad_step", 64'(sad), 64'(365 * k));
    end
    pulseClear();
    checkOutput("sad_clear", 64'(sad), 64'd0);

    // Back-pressure with two beats in flight
    ready_mode = 1;
    repeat (2) @(posedge clk);
    #1;
    applyStimulus(2'b10, {8'd1, 8'd2, 8'd3, 8'd4}, {8'd9, 8'd9, 8'd0, 8'd0});
    applyStimulus(2'b00, {8'd1, 8'd80, 8'd7, 8'd128}, '0);
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      checkOutput("stall_valid", 64'(out_valid), 64'd1);
      checkOutput("stall_in_ready", 64'(in_ready), 64'd0);
      checkOutput("stall_y", 64'(y), 64'h08_07_03_04);
    end
    ready_mode = 0;
    drain();

    // Accumulator saturation
    pulseClear();
    for (int k = 0; k < 66; k++) applyStimulus(2'b11, 32'hFFFF_FFFF, '0);
    drain();
    checkOutput("sat_sad", 64'(sad), 64'd65535);
    checkOutput("sat_acc_ovf", 64'(acc_ovf), 64'd1);
    applyStimulus(2'b11, 32'h0101_0101, '0);
    drain();
    checkOutput("sat_hold", 64'(sad), 64'd65535);
    pulseClear();
    checkOutput("sat_clr_sad", 64'(sad), 64'd0);
    checkOutput("sat_clr_ovf", 64'(acc_ovf), 64'd0);

    // Reset mid-stream
    applyStimulus(2'b11, {8'd255, 8'd0, 8'd200, 8'd10}, {8'd0, 8'd0, 8'd100, 8'd20});
    drain();
    applyStimulus(2'b01, 32'h1234_5678, '0);
    applyStimulus(2'b11, 32'hFFFF_FFFF, '0);
    rst_n = 1'b0;
    sb.delete();
    #1;
    checkOutput("mid_rst_valid", 64'(out_valid), 64'd0);
    checkOutput("mid_rst_sad", 64'(sad), 64'd0);
    checkOutput("mid_rst_ready", 64'(in_ready), 64'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      checkOutput("post_rst_valid", 64'(out_valid), 64'd0);
    end
    @(posedge clk);
    #1;

    // Randomized traffic with bubbles, back-pressure and occasional clears
    ready_mode = 2;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 4) == 0) ra[8*$urandom_range(0, 3) +: 8] = 8'h80;
      acc_clr = ($urandom_range(0, 15) == 0);
      applyStimulus(2'($urandom_range(0, 3)), ra, rb);
      acc_clr = 1'b0;
    end
    ready_mode = 0;
    drain();
    checkOutput("final_empty", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/twos_comp_pipe.md
TWOS_COMP_PIPE -- requirements
Module: twos_comp_pipe

Interface
REQ-001 Parameter WIDTH, default 8, lane operand width in bits (>=2).
REQ-002 Parameter LANES, default 4, number of parallel lanes (>=1).
REQ-003 Parameter ACC_WIDTH, default 16, SAD accumulator width (>=WIDTH+clog2(LANES)).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  in  1  input beat valid.
REQ-007 in_ready  out  1  block can accept a beat this cycle.
REQ-008 mode  in  2  00 NEG, 01 ABS, 10 ABSDIFF, 11 SAD; sampled with the beat.
REQ-009 a  in  LANES*WIDTH  operand A, lane i at [i*WIDTH +: WIDTH].
REQ-010 b  in  LANES*WIDTH  operand B; used only in ABSDIFF/SAD.
REQ-011 acc_clr  in  1  synchronous accumulator clear.
REQ-012 out_valid  out  1  result beat valid.
REQ-013 out_ready  in  1  downstream accepts result.
REQ-014 y  out  LANES*WIDTH  per-lane result.
REQ-015 ovf  out  LANES  per-lane overflow flag, aligned with y.
REQ-016 sad  out  ACC_WIDTH  running SAD accumulator.
REQ-017 acc_ovf  out  1  sticky accumulator saturation flag.

Function
REQ-018 NEG: y = -a (two's complement, ~a+1), a signed; ovf=1 only when a = -2^(WIDTH-1).
REQ-019 ABS: y = |a|, a signed; ovf=1 only when a = -2^(WIDTH-1); otherwise 0.
REQ-020 ABSDIFF and SAD: a, b unsigned; y = |a-b| computed at WIDTH+1 bits, result fits WIDTH; ovf=0.
REQ-021 Two-stage pipeline: stage 1 registers difference/negation, stage 2 registers abs select, lane sum and flags.
REQ-022 Global advance en = !out_valid || out_ready; in_ready = en; beat accepted when in_valid && in_ready.
REQ-023 Latency exactly 2 cycles from acceptance to out_valid with out_ready held high; throughput one beat per cycle.
REQ-024 While out_valid && !out_ready, y, ovf, out_valid and both stages hold unchanged.
REQ-025 Bubbles (in_valid low while en) propagate as invalid stages; no beat is dropped or duplicated.
REQ-026 sad updates only when a SAD-mode beat completes (out_valid && out_ready): sad += sum of LANES y values.
REQ-027 sad saturates at 2^ACC_WIDTH-1; on saturation acc_ovf sets and stays set until acc_clr or reset.
REQ-028 acc_clr alone: sad=0, acc_ovf=0 next cycle; acc_clr with a completing SAD beat: sad = that beat's sum.
REQ-029 Mode may change every beat; each beat carries its own mode through the pipeline.

Reset
REQ-030 rst_n low: out_valid=0, y=0, ovf=0, sad=0, acc_ovf=0, stage valids=0, immediately.
REQ-031 in_ready = 1 during and after reset; in-flight beats at reset are discarded.

Configuration
REQ-032 TWOS_COMP_SAT_EN defined: NEG/ABS of -2^(WIDTH-1) yields 2^(WIDTH-1)-1, ovf still 1.
REQ-033 TWOS_COMP_SAT_EN undefined: that case wraps to bit pattern 2^(WIDTH-1), ovf=1.

Structure
REQ-034 Package twos_comp_pkg holds mode enum (MODE_NEG, MODE_ABS, MODE_ABSDIFF, MODE_SAD) and default WIDTH/LANES/ACC_WIDTH constants.
REQ-035 Sub-module twos_comp_lane implements one lane's stage-1/stage-2 datapath and ovf; top instantiates LANES copies plus handshake and accumulator.

Verification (WIDTH=8, LANES=4, ACC_WIDTH=16)
REQ-036 NEG, a lanes {5,-1,0,127} -> 2 cycles later y {-5,1,0,-127}, ovf 0000.
REQ-037 ABS, a lane0 = -128 -> ovf[0]=1, y lane0 = 0x80 without macro, 0x7F with TWOS_COMP_SAT_EN.
REQ-038 SAD, a {10,200,0,255}, b {20,100,0,0}, three beats -> sad = 365, 730, 1095; then acc_clr -> sad=0.
REQ-039 out_ready low 3 cycles with 2 beats in flight -> y/out_valid held, in_ready=0, both beats delivered in order after release.
REQ-040 SAD beats of sum 1020 repeated until 65535 -> sad pins at 65535, acc_ovf=1 until acc_clr.
REQ-041 rst_n asserted mid-stream with 2 beats in flight -> out_valid=0, sad=0 immediately; no stale beat after release.
